// File: rtl/ccff_chain_loader_if.sv
// Programming-controller side of the configuration chain loader: bitstream
// input handshake, readback output handshake and operation status.
interface ccff_chain_loader_if #(
   parameter int unsigned WORD_W = 8
) ();

   logic              cfg_start;
   logic              cfg_mode;
   logic              cfg_chk;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              busy;
   logic              done;
   logic              tail_err;

   // Programming controller
   modport master (
      output cfg_start, cfg_mode, cfg_chk, cfg_data, cfg_valid, rd_ready,
      input  cfg_ready, rd_data, rd_valid, busy, done, tail_err
   );

   // Chain loader
   modport slave (
      input  cfg_start, cfg_mode, cfg_chk, cfg_data, cfg_valid, rd_ready,
      output cfg_ready, rd_data, rd_valid, busy, done, tail_err
   );

endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader for a CLB tile scan chain (ccff_head -> ccff_tail).
// LOAD serialises bitstream words into the chain LSB first; ROTATE feeds the
// tail back into the head so the chain is read out as words and left intact.
module ccff_chain_loader #(
   parameter int unsigned CHAIN_LEN = 12,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                prog_clk,
   input  logic                pReset,
   ccff_chain_loader_if.slave  bus,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                ccff_shift_en
);

   localparam int unsigned AW = $clog2(WORD_W + 1);
   localparam int unsigned PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [CNT_W-1:0] LenC     = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] WordC    = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [AW-1:0]    AvailOne = AW'(1);
   localparam logic [AW-1:0]    AvailMax = AW'(WORD_W);
   localparam logic [PW-1:0]    LastPos  = PW'(WORD_W - 1);
   localparam logic [PW-1:0]    PosOne   = PW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRotate
   } state_e;

   state_e              state_q, state_d;
   logic                chk_q, chk_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   sr_q, sr_d;
   logic [AW-1:0]       avail_q, avail_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic [WORD_W-1:0]   col_q, col_d;
   logic [WORD_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                tail_err_q, tail_err_d;
   logic                done_q, done_d;

   logic                cfg_ready;
   logic                accept;
   logic                word_end;
   logic                stall;
   logic [CNT_W-1:0]    remaining;

   // Next-state, chain drive and handshake decode
   always_comb begin
      state_d    = state_q;
      chk_d      = chk_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      avail_d    = avail_q;
      pos_d      = pos_q;
      col_d      = col_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      tail_err_d = tail_err_q;
      done_d     = 1'b0;

      cfg_ready     = 1'b0;
      accept        = 1'b0;
      word_end      = 1'b0;
      stall         = 1'b0;
      remaining     = '0;
      ccff_head     = 1'b0;
      ccff_shift_en = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.cfg_start) begin
               chk_d      = bus.cfg_chk;
               cnt_d      = '0;
               tail_err_d = 1'b0;
               sr_d       = '0;
               avail_d    = '0;
               pos_d      = '0;
               col_d      = '0;
               state_d    = bus.cfg_mode ? StRotate : StLoad;
            end
         end

         StLoad: begin
            // Look ahead from avail == 1 so the next word lands without a gap
            cfg_ready = ((avail_q == '0) && (cnt_q < LenC)) ||
                        ((avail_q == AvailOne) && ((cnt_q + CntOne) < LenC));
            accept    = cfg_ready && bus.cfg_valid;

            if (avail_q != '0) begin
               ccff_head     = sr_q[0];
               ccff_shift_en = 1'b1;
               sr_d          = sr_q >> 1;
               avail_d       = avail_q - AvailOne;
               cnt_d         = cnt_q + CntOne;
               if (chk_q && ccff_tail) begin
                  tail_err_d = 1'b1;
               end
            end

            // Only the bits still owed to the chain count; the rest of the word is dropped
            if (accept) begin
               sr_d      = bus.cfg_data;
               remaining = LenC - cnt_d;
               avail_d   = (remaining >= WordC) ? AvailMax : AW'(remaining);
            end

            if (cnt_d == LenC) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end

         StRotate: begin
            ccff_head = ccff_tail;

            if (rd_valid_q && bus.rd_ready) begin
               rd_valid_d = 1'b0;
            end

            if (cnt_q < LenC) begin
               word_end = (pos_q == LastPos) || (cnt_q == (LenC - CntOne));
               // Hold the chain rather than overwrite a word the consumer has not taken
               stall    = rd_valid_q && !bus.rd_ready && word_end;

               if (!stall) begin
                  ccff_shift_en = 1'b1;
                  cnt_d         = cnt_q + CntOne;
                  if (word_end) begin
                     rd_data_d        = col_q;
                     rd_data_d[pos_q] = ccff_tail;
                     rd_valid_d       = 1'b1;
                     col_d            = '0;
                     pos_d            = '0;
                  end else begin
                     col_d[pos_q] = ccff_tail;
                     pos_d        = pos_q + PosOne;
                  end
               end
            end else if (!rd_valid_q || bus.rd_ready) begin
               rd_valid_d = 1'b0;
               state_d    = StIdle;
               done_d     = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q    <= StIdle;
         chk_q      <= 1'b0;
         cnt_q      <= '0;
         sr_q       <= '0;
         avail_q    <= '0;
         pos_q      <= '0;
         col_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         tail_err_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         chk_q      <= chk_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         avail_q    <= avail_d;
         pos_q      <= pos_d;
         col_q      <= col_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         tail_err_q <= tail_err_d;
         done_q     <= done_d;
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = done_q;
   assign bus.tail_err  = tail_err_q;

endmodule
